// File: rtl/vco_band_cal.sv
// Coarse VCO band calibration: binary search on a 5-bit tune word against a pulse-count target.
// Optional VCO_CAL_NEIGHBOR_EN adds a final comparison against band tune+1.
module vco_band_cal #(
   parameter int unsigned WIN_CYCLES    = 256,
   parameter int unsigned TARGET        = 128,
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned CNT_W         = 16
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             start,
   input  logic             vco_pulse,
   output logic [4:0]       tune,
   output logic             vctrl_hold,
   output logic             busy,
   output logic             done,
   output logic             cal_fail,
   output logic [CNT_W-1:0] last_count
);

   localparam int unsigned TMAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
   localparam int unsigned TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0]  SET_LD  = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0]  WIN_LD  = TW'(WIN_CYCLES - 1);
   localparam logic [CNT_W:0] TGT     = TARGET[CNT_W:0];

   localparam logic [2:0] StIdle       = 3'd0;
   localparam logic [2:0] StSettle     = 3'd1;
   localparam logic [2:0] StMeasure    = 3'd2;
   localparam logic [2:0] StDecide     = 3'd3;
   localparam logic [2:0] StDone       = 3'd4;
`ifdef VCO_CAL_NEIGHBOR_EN
   localparam logic [2:0] StNbrSettle  = 3'd5;
   localparam logic [2:0] StNbrMeasure = 3'd6;
`endif

   logic [2:0]       state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [CNT_W-1:0] pulse_q, pulse_d, pulse_inc;
   logic [CNT_W-1:0] last_q, last_d;
   logic [4:0]       tune_q, tune_d, tune_dec;
   logic [2:0]       bit_q, bit_d;
   logic             fail_q, fail_d;
`ifdef VCO_CAL_NEIGHBOR_EN
   logic             nbr_q, nbr_d;
   logic [CNT_W-1:0] base_q, base_d;

   function automatic logic [CNT_W:0] dist(input logic [CNT_W-1:0] c);
      logic [CNT_W:0] e;
      e = {1'b0, c};
      return (e > TGT) ? (e - TGT) : (TGT - e);
   endfunction
`endif

   // A rail hit means the search could not bracket the target.
   function automatic logic fail_of(input logic [4:0] t, input logic [CNT_W-1:0] c);
      return (t == 5'd0) || ((t == 5'd31) && ({1'b0, c} < TGT));
   endfunction

   assign pulse_inc = (vco_pulse && (pulse_q != '1)) ? pulse_q + CNT_W'(1) : pulse_q;

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      pulse_d  = pulse_q;
      last_d   = last_q;
      tune_d   = tune_q;
      bit_d    = bit_q;
      fail_d   = fail_q;
      tune_dec = tune_q;
`ifdef VCO_CAL_NEIGHBOR_EN
      nbr_d    = nbr_q;
      base_d   = base_q;
`endif
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StSettle;
               timer_d = SET_LD;
               tune_d  = 5'b10000;
               bit_d   = 3'd4;
               fail_d  = 1'b0;
`ifdef VCO_CAL_NEIGHBOR_EN
               nbr_d   = 1'b0;
`endif
            end
         end
         StSettle: begin
            if (timer_q == '0) begin
               state_d = StMeasure;
               timer_d = WIN_LD;
               pulse_d = '0;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         StMeasure: begin
            pulse_d = pulse_inc;
            if (timer_q == '0) begin
               last_d  = pulse_inc;
               state_d = StDecide;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
`ifdef VCO_CAL_NEIGHBOR_EN
         StNbrSettle: begin
            if (timer_q == '0) begin
               state_d = StNbrMeasure;
               timer_d = WIN_LD;
               pulse_d = '0;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         StNbrMeasure: begin
            pulse_d = pulse_inc;
            if (timer_q == '0) begin
               last_d  = pulse_inc;
               state_d = StDecide;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
`endif
         StDecide: begin
            if ({1'b0, last_q} > TGT) tune_dec[bit_q] = 1'b0;
`ifdef VCO_CAL_NEIGHBOR_EN
            // Second pass through DECIDE resolves the neighbour comparison; ties keep the lower band.
            if (nbr_q) begin
               nbr_d   = 1'b0;
               state_d = StDone;
               if (dist(last_q) < dist(base_q)) begin
                  fail_d = fail_of(tune_q, last_q);
               end else begin
                  tune_d = tune_q - 5'd1;
                  last_d = base_q;
                  fail_d = fail_of(tune_q - 5'd1, base_q);
               end
            end else
`endif
            if (bit_q != 3'd0) begin
               tune_d  = tune_dec | (5'd1 << (bit_q - 3'd1));
               bit_d   = bit_q - 3'd1;
               state_d = StSettle;
               timer_d = SET_LD;
            end else begin
`ifdef VCO_CAL_NEIGHBOR_EN
               if (tune_dec != 5'd31) begin
                  base_d  = last_q;
                  tune_d  = tune_dec + 5'd1;
                  nbr_d   = 1'b1;
                  state_d = StNbrSettle;
                  timer_d = SET_LD;
               end else begin
                  tune_d  = tune_dec;
                  fail_d  = fail_of(tune_dec, last_q);
                  state_d = StDone;
               end
`else
               tune_d  = tune_dec;
               fail_d  = fail_of(tune_dec, last_q);
               state_d = StDone;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q <= StIdle;
         timer_q <= '0;
         pulse_q <= '0;
         last_q  <= '0;
         tune_q  <= 5'b01111;
         bit_q   <= 3'd4;
         fail_q  <= 1'b0;
`ifdef VCO_CAL_NEIGHBOR_EN
         nbr_q   <= 1'b0;
         base_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         pulse_q <= pulse_d;
         last_q  <= last_d;
         tune_q  <= tune_d;
         bit_q   <= bit_d;
         fail_q  <= fail_d;
`ifdef VCO_CAL_NEIGHBOR_EN
         nbr_q   <= nbr_d;
         base_q  <= base_d;
`endif
      end
   end

   assign busy       = (state_q != StIdle) && (state_q != StDone);
   assign vctrl_hold = busy;
   assign done       = (state_q == StDone);
   assign cal_fail   = fail_q;
   assign tune       = tune_q;
   assign last_count = last_q;

endmodule

// File: tb/tb_vco_band_cal.sv
// Directed bench for vco_band_cal: table of VCO pulse models plus reset/restart/saturation sequences.
module tb_vco_band_cal;

   logic        refclk;
   logic        rst;
   logic        start;
   logic        start2;
   logic        vco_pulse;
   logic [4:0]  tune;
   logic        vctrl_hold, busy, done, cal_fail;
   logic [15:0] last_count;
   logic [4:0]  tune2;
   logic        vctrl_hold2, busy2, done2, cal_fail2;
   logic [7:0]  last_count2;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          mode = 0;
   logic [7:0]  ph = 8'd0;
   int          k;

   vco_band_cal u_dut (
      .refclk     (refclk),
      .rst        (rst),
      .start      (start),
      .vco_pulse  (vco_pulse),
      .tune       (tune),
      .vctrl_hold (vctrl_hold),
      .busy       (busy),
      .done       (done),
      .cal_fail   (cal_fail),
      .last_count (last_count)
   );

   vco_band_cal #(
      .WIN_CYCLES (300),
      .CNT_W      (8)
   ) u_sat (
      .refclk     (refclk),
      .rst        (rst),
      .start      (start2),
      .vco_pulse  (1'b1),
      .tune       (tune2),
      .vctrl_hold (vctrl_hold2),
      .busy       (busy2),
      .done       (done2),
      .cal_fail   (cal_fail2),
      .last_count (last_count2)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   always @(posedge refclk) begin
      cyc <= cyc + 1;
      ph  <= ph + 8'd1;
   end

   // VCO model: a 256-periodic pattern with k ones yields exactly k pulses in any 256-cycle window.
   always_comb begin
      case (mode)
         0:       k = 8 * int'(tune);
         1:       k = 4 * int'(tune) + 10;
         2:       k = 0;
         3:       k = 256;
         4:       k = 128;
         default: k = 129;
      endcase
      vco_pulse = (int'(ph) < k);
   end

   typedef struct {
      int          mode;
      logic [4:0]  tune;
      logic [15:0] last;
      logic        fail;
   } vec_t;

   vec_t       vecs[6];
   logic [4:0] seq[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge refclk);
   endtask

   task automatic wait_done(input string nm, input int t0, output int lat);
      bit seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         if (done) seen = 1'b1;
         else @(negedge refclk);
      end
      lat = seen ? (cyc - t0) : -1;
      if (!seen) check({nm, " done timeout"}, 32'd0, 32'd1);
   endtask

   task automatic issue_start(output int t0);
      @(negedge refclk);
      start = 1'b1;
      t0 = cyc;
      @(negedge refclk);
      start = 1'b0;
   endtask

   task automatic run_cal(input string nm, output int lat);
      int t0;
      issue_start(t0);
      check({nm, " entry busy"}, 32'(busy), 32'd1);
      check({nm, " entry hold"}, 32'(vctrl_hold), 32'd1);
      check({nm, " entry done"}, 32'(done), 32'd0);
      check({nm, " entry fail"}, 32'(cal_fail), 32'd0);
      check({nm, " entry tune"}, 32'(tune), 32'd16);
      wait_done(nm, t0, lat);
   endtask

   initial begin
      int lat;
      int t0;
      string nm;

      vecs[0] = '{mode: 0, tune: 5'd16, last: 16'd136, fail: 1'b0};  // last window ran at tune 17
      vecs[1] = '{mode: 1, tune: 5'd29, last: 16'd126, fail: 1'b0};
      vecs[2] = '{mode: 2, tune: 5'd31, last: 16'd0,   fail: 1'b1};
      vecs[3] = '{mode: 3, tune: 5'd0,  last: 16'd256, fail: 1'b1};
      vecs[4] = '{mode: 4, tune: 5'd31, last: 16'd128, fail: 1'b0};  // equality keeps every bit
      vecs[5] = '{mode: 5, tune: 5'd0,  last: 16'd129, fail: 1'b1};
      seq = '{5'd16, 5'd24, 5'd20, 5'd18, 5'd17};

      rst = 1'b1;
      start = 1'b0;
      start2 = 1'b0;
      repeat (3) @(negedge refclk);
      check("reset tune", 32'(tune), 32'd15);
      check("reset busy", 32'(busy), 32'd0);
      check("reset hold", 32'(vctrl_hold), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset fail", 32'(cal_fail), 32'd0);
      check("reset last", 32'(last_count), 32'd0);

      // start coincident with rst must be dropped
      start = 1'b1;
      @(negedge refclk);
      rst = 1'b0;
      start = 1'b0;
      @(negedge refclk);
      check("start during rst busy", 32'(busy), 32'd0);
      check("start during rst tune", 32'(tune), 32'd15);

      foreach (vecs[i]) begin
         mode = vecs[i].mode;
         nm = $sformatf("vec%0d", i);
         run_cal(nm, lat);
         check({nm, " latency"}, 32'(lat), 32'd1366);
         check({nm, " tune"}, 32'(tune), 32'(vecs[i].tune));
         check({nm, " last_count"}, 32'(last_count), 32'(vecs[i].last));
         check({nm, " cal_fail"}, 32'(cal_fail), 32'(vecs[i].fail));
         check({nm, " busy"}, 32'(busy), 32'd0);
         check({nm, " hold"}, 32'(vctrl_hold), 32'd0);
      end

      // Restart from DONE (previous result tune=0, cal_fail=1), then reset in third MEASURE.
      mode = 0;
      issue_start(t0);
      check("restart done", 32'(done), 32'd0);
      check("restart fail", 32'(cal_fail), 32'd0);
      check("restart busy", 32'(busy), 32'd1);
      check("restart tune", 32'(tune), 32'd16);
      wait_cyc(t0 + 600);
      rst = 1'b1;
      @(negedge refclk);
      rst = 1'b0;
      check("midrst tune", 32'(tune), 32'd15);
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst done", 32'(done), 32'd0);
      check("midrst hold", 32'(vctrl_hold), 32'd0);
      check("midrst last", 32'(last_count), 32'd0);
      run_cal("post-rst", lat);
      check("post-rst latency", 32'(lat), 32'd1366);
      check("post-rst tune", 32'(tune), 32'd16);

      // start pulses while busy must not disturb the search
      issue_start(t0);
      for (int i = 0; i < 5; i++) begin
         wait_cyc(t0 + 1 + 273 * i + 100);
         check($sformatf("seq tune%0d", i), 32'(tune), 32'(seq[i]));
         start = 1'b1;
         @(negedge refclk);
         start = 1'b0;
      end
      wait_done("busy-start", t0, lat);
      check("busy-start latency", 32'(lat), 32'd1366);
      check("busy-start tune", 32'(tune), 32'd16);

      // Narrow counter must saturate at 255 rather than wrap to 300 mod 256
      @(negedge refclk);
      start2 = 1'b1;
      t0 = cyc;
      @(negedge refclk);
      start2 = 1'b0;
      wait_cyc(t0 + 1 + 16 + 300 + 5);
      check("sat first window", 32'(last_count2), 32'd255);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 3000 && !seen; i++) begin
            if (done2) seen = 1'b1;
            else @(negedge refclk);
         end
         check("sat done seen", 32'(seen), 32'd1);
         if (seen) check("sat latency", 32'(cyc - t0), 32'd1586);
      end
      check("sat tune", 32'(tune2), 32'd0);
      check("sat last_count", 32'(last_count2), 32'd255);
      check("sat cal_fail", 32'(cal_fail2), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", errors + 1,
               checks + 1);
      $fatal(1, "watchdog");
   end

endmodule
